// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// dmem_pkg : shared types and helpers for the data-memory responder
// Rev 1.0
// ============================================================================
package dmem_pkg;

   localparam int unsigned WORD_ADDR_W = 30;

   typedef struct packed {
      logic [WORD_ADDR_W-1:0] addr;
      logic [31:0]            data;
      logic [3:0]             mask;
   } wb_entry_t;

   typedef enum logic [1:0] {
      DR_IDLE   = 2'd0,
      DR_WAIT   = 2'd1,
      DR_COMMIT = 2'd2
   } drain_state_t;

   function automatic logic [3:0] lane_mask(input logic byte_en, input logic [1:0] lane);
      lane_mask = byte_en ? (4'b0001 << lane) : 4'b1111;
   endfunction

   // Little-endian merge: lane l of upd replaces lane l of base where mask[l] is set.
   function automatic logic [31:0] merge_lanes(input logic [31:0] base,
                                               input logic [31:0] upd,
                                               input logic [3:0]  mask);
      logic [31:0] r;
      r = base;
      for (int l = 0; l < 4; l++) begin
         if (mask[l]) r[8*l +: 8] = upd[8*l +: 8];
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_wbuf.sv
`default_nettype none
// ============================================================================
// dmem_wbuf : circular posted-write buffer; entries exposed oldest-first
// Rev 1.0
// ============================================================================
module dmem_wbuf
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  wb_entry_t                    push_entry_i,
   input  logic                         pop_i,
   output wb_entry_t                    head_o,
   output logic                         full_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output wb_entry_t                    age_entry_o [DEPTH],
   output logic [DEPTH-1:0]             age_valid_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   wb_entry_t         mem_q [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              push_ok;
   logic              pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[head_q];
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && (count_q != '0);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_ok)  head_d = head_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[tail_q] <= push_entry_i;
   end

   // Slot k of the age view is the k-th oldest entry (k = 0 is the head).
   for (genvar k = 0; k < DEPTH; k++) begin : g_age
      logic [PTR_W-1:0] idx;
      assign idx            = head_q + PTR_W'(k);
      assign age_entry_o[k] = mem_q[idx];
      assign age_valid_o[k] = (CNT_W'(k) < count_q);
   end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder : M-stage data-memory responder with posted write buffer,
//                  timed drain to word RAM and byte-lane read forwarding
// Rev 1.0
// ============================================================================
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 6,
   parameter int unsigned WB_DEPTH    = 4,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            MemWriteM,
   input  logic [31:0]                     ALUResult,
   input  logic [31:0]                     WriteData,
   input  logic                            be,
   output logic [31:0]                     ReadData,
   output logic                            StallM,
   output logic [$clog2(WB_DEPTH+1)-1:0]   WbCount,
   output logic                            Busy
);

   localparam int unsigned       CNT_W       = $clog2(WB_DEPTH + 1);
   localparam int unsigned       WAIT_W      = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(WAIT_STATES - 1);

   logic [31:0]            ram_q [2**ADDR_WIDTH];
   drain_state_t           state_q, state_d;
   logic [WAIT_W-1:0]      wait_q, wait_d;
   logic                   push;
   logic                   pop;
   logic                   full;
   logic [CNT_W-1:0]       count;
   wb_entry_t              push_entry;
   wb_entry_t              head;
   wb_entry_t              age_entry [WB_DEPTH];
   logic [WB_DEPTH-1:0]    age_valid;
   logic [ADDR_WIDTH-1:0]  word_addr;
   logic [ADDR_WIDTH-1:0]  head_addr;
   logic [31:0]            fwd_word;
   logic                   unused_bits;

   assign word_addr   = ALUResult[ADDR_WIDTH+1:2];
   assign head_addr   = head.addr[ADDR_WIDTH-1:0];
   assign unused_bits = ^{ALUResult[31:ADDR_WIDTH+2], head.addr[WORD_ADDR_W-1:ADDR_WIDTH]};

   // A commit in the same cycle does not relieve a full buffer.
   assign StallM  = MemWriteM && full;
   assign push    = MemWriteM && !full;
   assign WbCount = count;
   assign Busy    = (count != '0);

   always_comb begin
      push_entry.addr = WORD_ADDR_W'(word_addr);
      push_entry.mask = lane_mask(be, ALUResult[1:0]);
      push_entry.data = be ? {4{WriteData[7:0]}} : WriteData;
   end

   dmem_wbuf #(
      .DEPTH (WB_DEPTH)
   ) u_wbuf (
      .clk_i        (clk),
      .rst_i        (reset),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_o       (head),
      .full_o       (full),
      .count_o      (count),
      .age_entry_o  (age_entry),
      .age_valid_o  (age_valid)
   );

   // IDLE also reacts to an incoming push so the first commit lands
   // WAIT_STATES+1 edges after the enqueue edge.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      pop     = 1'b0;
      case (state_q)
         DR_IDLE: begin
            if (push || (count != '0)) begin
               state_d = DR_WAIT;
               wait_d  = WAIT_RELOAD;
            end
         end
         DR_WAIT: begin
            if (wait_q == '0) state_d = DR_COMMIT;
            else              wait_d  = wait_q - 1'b1;
         end
         DR_COMMIT: begin
            pop = 1'b1;
            if ((count > CNT_W'(1)) || push) begin
               state_d = DR_WAIT;
               wait_d  = WAIT_RELOAD;
            end else begin
               state_d = DR_IDLE;
            end
         end
         default: state_d = DR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= DR_IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) ram_q[head_addr] <= merge_lanes(ram_q[head_addr], head.data, head.mask);
   end

   // Oldest to newest so the youngest store wins each lane; the committing
   // head is still visible here in its commit cycle.
   always_comb begin
      fwd_word = ram_q[word_addr];
      for (int k = 0; k < WB_DEPTH; k++) begin
         if (age_valid[k] && (age_entry[k].addr == WORD_ADDR_W'(word_addr)))
            fwd_word = merge_lanes(fwd_word, age_entry[k].data, age_entry[k].mask);
      end
   end

   assign ReadData = be ? {24'b0, fwd_word[{ALUResult[1:0], 3'b000} +: 8]} : fwd_word;

endmodule
`default_nettype wire
